// File: rtl/flappy_pkg.sv
// flappy_pkg: shared state encodings, screen/pipe constants and gap-sequence helpers
package flappy_pkg;
  typedef enum logic [2:0] {S_IDLE = 3'b001, S_RUN = 3'b010, S_OVER = 3'b100} state_t;
  localparam int PIPE_WIDTH = 80;
  localparam int GAP_HEIGHT = 100;
  localparam int SCREEN_W = 640;
  localparam int RESET_Y = 100;
  localparam logic [9:0] LFSR_SEED = 10'h001;
  function automatic logic [9:0] fixed_gap(input logic [1:0] i);
    return i == 2'd0 ? 10'd60 : i == 2'd1 ? 10'd140 : i == 2'd2 ? 10'd100 : 10'd180;
  endfunction
  function automatic logic [9:0] lfsr_step(input logic [9:0] s);
    return {s[8:0], s[9] ^ s[6]};
  endfunction
endpackage

// File: rtl/pipe_scheduler_gap_gen.sv
// gap_gen: gap-top source; Gap is the next value, Gap_More the N-1 values after it.
// Ports: Clk, reset (sync, active-high), Next = number of values consumed this cycle (mod 4),
// Gap[9:0] head value, Gap_More[10*(N-1)-1:0] following values.
// PIPE_RANDOM_EN: 10-bit Fibonacci LFSR (taps 10,7) stepping every cycle, value 40+lfsr[6:0];
// otherwise the cyclic table 60,140,100,180 advancing only on consumption.
module gap_gen
  import flappy_pkg::*;
#(
  parameter int N = 3
) (
  input  logic                  Clk,
  input  logic                  reset,
  input  logic [1:0]            Next,
  output logic [9:0]            Gap,
  output logic [10*(N-1)-1:0]   Gap_More
);
  logic [N-1:0][9:0] vals;
`ifdef PIPE_RANDOM_EN
  logic [9:0] lfsr_q, lfsr_d;
  logic [N-1:0][9:0] s;
  always_comb begin
    lfsr_d = lfsr_step(lfsr_q);
    s[0] = lfsr_q;
    for (int i = 1; i < N; i++) s[i] = lfsr_step(s[i-1]);
    for (int i = 0; i < N; i++) vals[i] = 10'd40 + {3'd0, s[i][6:0]};
  end
  always_ff @(posedge Clk) lfsr_q <= reset ? LFSR_SEED : lfsr_d;
`else
  logic [1:0] ptr_q, ptr_d;
  always_comb begin
    ptr_d = ptr_q + Next;
    for (int i = 0; i < N; i++) vals[i] = fixed_gap(ptr_q + 2'(i));
  end
  always_ff @(posedge Clk) ptr_q <= reset ? 2'd0 : ptr_d;
`endif
  assign Gap = vals[0];
  assign Gap_More = vals[N-1:1];
endmodule

// File: rtl/pipe_scheduler.sv
// pipe_scheduler: ring of scrolling pipes with scoring and an IDLE/RUN/OVER game FSM.
// Inputs: Clk, reset (sync, active-high), Start, Ack, Frame_Tick, Collide, Bird_X[9:0].
// Outputs: X_Edge/Y_Edge of the in-scope pipe, Pipe_X_All/Pipe_Y_All packed 10 bits per pipe,
// Score[7:0] (binary, saturating), one-hot Q_Idle/Q_Run/Q_Over.
// PIPE_RANDOM_EN selects the LFSR gap source inside gap_gen.
module pipe_scheduler
  import flappy_pkg::*;
#(
  parameter int NUM_PIPES = 3,
  parameter int PIPE_SPACING = 240,
  parameter int SPEED = 2
) (
  input  logic                      Clk,
  input  logic                      reset,
  input  logic                      Start,
  input  logic                      Ack,
  input  logic                      Frame_Tick,
  input  logic                      Collide,
  input  logic [9:0]                Bird_X,
  output logic [9:0]                X_Edge,
  output logic [9:0]                Y_Edge,
  output logic [10*NUM_PIPES-1:0]   Pipe_X_All,
  output logic [10*NUM_PIPES-1:0]   Pipe_Y_All,
  output logic [7:0]                Score,
  output logic                      Q_Idle,
  output logic                      Q_Run,
  output logic                      Q_Over
);
  localparam int CW = $clog2(NUM_PIPES);
  localparam logic [9:0] SPD = 10'(SPEED);
  localparam logic [9:0] WRAP = 10'(NUM_PIPES * PIPE_SPACING - SPEED);
  state_t state_q, state_d;
  logic [7:0] score_q, score_d;
  logic [CW-1:0] cur_q, cur_d;
  logic [NUM_PIPES-1:0][9:0] px_q, px_d, py_q, py_d, gaps;
  logic [2:0] k;
  logic hit;
  gap_gen #(.N(NUM_PIPES)) u_gap (
    .Clk      (Clk),
    .reset    (reset),
    .Next     (k[1:0]),
    .Gap      (gaps[0]),
    .Gap_More (gaps[NUM_PIPES-1:1])
  );
  always_comb begin
    state_d = state_q;
    score_d = score_q;
    cur_d = cur_q;
    px_d = px_q;
    py_d = py_q;
    k = 3'd0;
    hit = {1'b0, Bird_X} > {1'b0, px_q[cur_q]} + 11'(PIPE_WIDTH);
    if (state_q == S_IDLE && Start) begin
      state_d = S_RUN;
      score_d = 8'd0;
      cur_d = '0;
      for (int i = 0; i < NUM_PIPES; i++) begin
        px_d[i] = 10'(SCREEN_W + i * PIPE_SPACING);
        py_d[i] = gaps[i];
      end
      k = 3'(NUM_PIPES);
    end else if (state_q == S_RUN && Collide) begin
      state_d = S_OVER;
    end else if (state_q == S_RUN) begin
      if (hit) begin
        score_d = score_q + {7'd0, score_q != 8'hff};
        cur_d = cur_q == CW'(NUM_PIPES - 1) ? '0 : cur_q + 1'b1;
      end
      // recycled pipes take successive gap values in pipe-index order
      if (Frame_Tick)
        for (int i = 0; i < NUM_PIPES; i++)
          if (px_q[i] < SPD) begin
            px_d[i] = px_q[i] + WRAP;
            py_d[i] = gaps[CW'(k)];
            k = k + 3'd1;
          end else px_d[i] = px_q[i] - SPD;
    end else if (state_q == S_OVER && Ack) begin
      state_d = S_IDLE;
    end
  end
  always_ff @(posedge Clk)
    if (reset) begin
      state_q <= S_IDLE;
      score_q <= 8'd0;
      cur_q <= '0;
      px_q <= {NUM_PIPES{10'(SCREEN_W)}};
      py_q <= {NUM_PIPES{10'(RESET_Y)}};
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      cur_q <= cur_d;
      px_q <= px_d;
      py_q <= py_d;
    end
  assign X_Edge = px_q[cur_q];
  assign Y_Edge = py_q[cur_q];
  assign Pipe_X_All = px_q;
  assign Pipe_Y_All = py_q;
  assign Score = score_q;
  assign {Q_Over, Q_Run, Q_Idle} = state_q;
endmodule

// File: tb/tb_pipe_scheduler.sv
// tb_pipe_scheduler: directed stimulus, reference game model compared every cycle plus literal pins.
// Spacing 120 keeps 640 + 3*spacing inside 10 bits; speed 3 lets a pipe land on X=1.
module tb_pipe_scheduler;
  localparam int NP = 3;
  localparam int SP = 120;
  localparam int SPD = 3;
  logic Clk = 0, reset = 1, Start = 0, Ack = 0, Frame_Tick = 0, Collide = 0;
  logic [9:0] Bird_X = 10'd80;
  logic [9:0] X_Edge, Y_Edge;
  logic [10*NP-1:0] Pipe_X_All, Pipe_Y_All;
  logic [7:0] Score;
  logic Q_Idle, Q_Run, Q_Over;
  int checks = 0, errors = 0;
  int m_st, m_score, m_cur, m_gidx;
  int m_x[NP], m_y[NP];
  bit m_valid = 0;
  int tbl[4] = '{60, 140, 100, 180};

  pipe_scheduler #(.NUM_PIPES(NP), .PIPE_SPACING(SP), .SPEED(SPD)) dut (
    .Clk(Clk), .reset(reset), .Start(Start), .Ack(Ack), .Frame_Tick(Frame_Tick),
    .Collide(Collide), .Bird_X(Bird_X), .X_Edge(X_Edge), .Y_Edge(Y_Edge),
    .Pipe_X_All(Pipe_X_All), .Pipe_Y_All(Pipe_Y_All), .Score(Score),
    .Q_Idle(Q_Idle), .Q_Run(Q_Run), .Q_Over(Q_Over)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  function automatic int px(input int i);
    return int'(Pipe_X_All[10*i +: 10]);
  endfunction
  function automatic int py(input int i);
    return int'(Pipe_Y_All[10*i +: 10]);
  endfunction

  // game rules: 0=idle 1=run 2=over
  always @(posedge Clk) begin
    if (reset) begin
      m_valid = 1;
      m_st = 0; m_score = 0; m_cur = 0; m_gidx = 0;
      for (int i = 0; i < NP; i++) begin m_x[i] = 640; m_y[i] = 100; end
    end else if (m_st == 0) begin
      if (Start) begin
        m_st = 1; m_score = 0; m_cur = 0;
        for (int i = 0; i < NP; i++) begin
          m_x[i] = 640 + i * SP;
          m_y[i] = tbl[m_gidx % 4];
          m_gidx++;
        end
      end
    end else if (m_st == 1) begin
      if (Collide) m_st = 2;
      else begin
        if (int'(Bird_X) > m_x[m_cur] + 80) begin
          if (m_score < 255) m_score++;
          m_cur = (m_cur + 1) % NP;
        end
        if (Frame_Tick)
          for (int i = 0; i < NP; i++)
            if (m_x[i] < SPD) begin
              m_x[i] = m_x[i] + NP * SP - SPD;
              m_y[i] = tbl[m_gidx % 4];
              m_gidx++;
            end else m_x[i] = m_x[i] - SPD;
      end
    end else if (Ack) m_st = 0;
  end

  always @(negedge Clk)
    if (m_valid) begin
      chk("state", int'({Q_Over, Q_Run, Q_Idle}), 1 << m_st);
      chk("score", int'(Score), m_score);
      chk("x_edge", int'(X_Edge), m_x[m_cur]);
      chk("y_edge", int'(Y_Edge), m_y[m_cur]);
      for (int i = 0; i < NP; i++) begin
        chk($sformatf("pipe%0d_x", i), px(i), m_x[i]);
        chk($sformatf("pipe%0d_y", i), py(i), m_y[i]);
      end
    end

  task automatic step(input int n = 1);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic ticks(input int n);
    Frame_Tick = 1;
    step(n);
    Frame_Tick = 0;
  endtask

  initial begin
    step(2);
    reset = 0;
    chk("rst_idle", int'(Q_Idle), 1);
    chk("rst_x_all", int'(Pipe_X_All), int'({10'd640, 10'd640, 10'd640}));
    chk("rst_y_all", int'(Pipe_Y_All), int'({10'd100, 10'd100, 10'd100}));
    chk("rst_score", int'(Score), 0);
    ticks(2);
    chk("idle_tick_ignored", px(0), 640);
    Start = 1; step(); Start = 0;
    chk("start_run", int'(Q_Run), 1);
    chk("start_x_all", int'(Pipe_X_All), int'({10'd880, 10'd760, 10'd640}));
    chk("start_y_all", int'(Pipe_Y_All), int'({10'd100, 10'd140, 10'd60}));
    chk("start_score", int'(Score), 0);
    ticks(10);
    chk("tick10_p0", px(0), 610);
    chk("tick10_p2", px(2), 850);
    step(3);
    chk("no_tick_hold", px(0), 610);
    ticks(163);
    chk("p0_at_121", px(0), 121);
    Bird_X = 10'd201; step();
    chk("score_boundary", int'(Score), 0);
    Bird_X = 10'd202; Collide = 1; step(); Collide = 0;
    chk("collide_over", int'(Q_Over), 1);
    chk("collide_no_score", int'(Score), 0);
    Bird_X = 10'd80;
    ticks(2);
    chk("over_frozen", px(0), 121);
    Ack = 1; step(); Ack = 0;
    chk("ack_idle", int'(Q_Idle), 1);
    Start = 1; step(); Start = 0;
    chk("restart_y_all", int'(Pipe_Y_All), int'({10'd140, 10'd60, 10'd180}));
    ticks(173);
    Bird_X = 10'd202; step();
    chk("score_one", int'(Score), 1);
    chk("x_edge_pipe1", int'(X_Edge), 241);
    Bird_X = 10'd80;
    ticks(39);
    chk("p0_at_4", px(0), 4);
    ticks(1);
    chk("p0_at_1", px(0), 1);
    ticks(1);
    chk("recycle_x", px(0), 358);
    chk("recycle_y", py(0), 100);
    chk("p1_at_118", px(1), 118);
    Bird_X = 10'd198; Frame_Tick = 1; step(); Frame_Tick = 0;
    chk("pre_tick_compare", int'(Score), 1);
    chk("p1_at_115", px(1), 115);
    step();
    chk("post_tick_score", int'(Score), 2);
    Bird_X = 10'd80;
    Start = 1; step(); Start = 0;
    chk("start_in_run", int'(Q_Run), 1);
    reset = 1; step(); reset = 0;
    chk("midrun_rst_idle", int'(Q_Idle), 1);
    chk("midrun_rst_x", int'(Pipe_X_All), int'({10'd640, 10'd640, 10'd640}));
    chk("midrun_rst_y", int'(Pipe_Y_All), int'({10'd100, 10'd100, 10'd100}));
    chk("midrun_rst_score", int'(Score), 0);
    Collide = 1; step(); Collide = 0;
    chk("idle_collide", int'(Q_Idle), 1);
    Start = 1; step(); Start = 0;
    chk("seed_restart_y", int'(Pipe_Y_All), int'({10'd100, 10'd140, 10'd60}));
    Bird_X = 10'd1023;
    step(260);
    chk("saturate", int'(Score), 255);
    Collide = 1; step(); Collide = 0;
    Bird_X = 10'd80;
    chk("sat_over", int'(Q_Over), 1);
    ticks(1);
    Ack = 1; step(); Ack = 0;
    chk("sat_idle", int'(Q_Idle), 1);
    chk("sat_held", int'(Score), 255);
    Start = 1; step(); Start = 0;
    chk("sat_cleared", int'(Score), 0);
    step(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
